breather_multi: RTL

//  Parametrised multi-channel breathing-light controller; next generation of the single-RGB breather.
//  - Triangle-wave brightness level with configurable PWM resolution and step period.
//  - Runtime mode select: off / solid / breathe / blink.
//  - Enable/pause and a period marker output.

---
 rtl/breather_multi.sv | 132 +++++++++++++
 1 files changed

// File: rtl/breather_multi.sv
// Multi-channel breathing-light controller: triangle/blink brightness level driving a PWM mask
// that gates CHANNELS colour enables onto registered LED outputs.
module breather_multi #(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 4,
  parameter int STEP_TICKS = 9765625,
  parameter int CNT_W      = 32
) (
  input  logic                clk_div_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] rgb_i,
  input  logic [1:0]          mode_i,
  input  logic                en_i,
  output logic [CHANNELS-1:0] rgb_o,
  output logic [PWM_BITS-1:0] level_o,
  output logic                period_o
);

  // mode_q: OFF=00 dark | SOLID=01 full on | BREATHE=10 triangle level | BLINK=11 square level
  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_SOLID   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = LVL_MAX - LVL_ONE;
  localparam logic [CNT_W-1:0]    STEP_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                dir_up_q, dir_up_d;
  logic                period_q, period_d;
  logic [CHANNELS-1:0] rgb_q, rgb_d;

  logic mode_chg;
  logic stepping;
  logic step_tick;
  logic mask;

  assign mode_chg  = (mode_i != mode_q);
  assign stepping  = mode_q[1];
  assign step_tick = en_i & stepping & (step_cnt_q == STEP_LAST);

  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q     <= MODE_OFF;
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      level_q    <= LVL_MAX;
      dir_up_q   <= 1'b0;
      period_q   <= 1'b0;
      rgb_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      level_q    <= level_d;
      dir_up_q   <= dir_up_d;
      period_q   <= period_d;
      rgb_q      <= rgb_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    step_cnt_d = step_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    level_d    = level_q;
    dir_up_d   = dir_up_q;
    period_d   = period_q;
    if (mode_chg) begin
      mode_d     = mode_i;
      step_cnt_d = '0;
      pwm_cnt_d  = '0;
      level_d    = LVL_MAX;
      dir_up_d   = 1'b0;
    end else if (en_i) begin
      pwm_cnt_d = (pwm_cnt_q >= PWM_LAST) ? '0 : pwm_cnt_q + LVL_ONE;
      if (stepping) begin
        step_cnt_d = step_tick ? '0 : step_cnt_q + CNT_ONE;
      end else begin
        step_cnt_d = '0;
      end
      case (mode_q)
        MODE_SOLID: level_d = LVL_MAX;
        MODE_BREATHE: begin
          // Saturating at both ends; the turn-around happens one step before the rail.
          if (step_tick) begin
            if (dir_up_q) begin
              if (level_q != LVL_MAX) level_d = level_q + LVL_ONE;
              if (level_q >= PWM_LAST) begin
                dir_up_d = 1'b0;
                period_d = ~period_q;
              end
            end else begin
              if (level_q != '0) level_d = level_q - LVL_ONE;
              if (level_q <= LVL_ONE) begin
                dir_up_d = 1'b1;
                period_d = ~period_q;
              end
            end
          end
        end
        MODE_BLINK: begin
          if (step_tick) begin
            level_d  = (level_q == '0) ? LVL_MAX : '0;
            period_d = ~period_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (mode_q)
      MODE_OFF:   mask = 1'b0;
      MODE_SOLID: mask = 1'b1;
      default:    mask = (pwm_cnt_q < level_q);
    endcase
    rgb_d = rgb_i & {CHANNELS{mask}} & {CHANNELS{en_i}};
  end

  assign rgb_o    = rgb_q;
  assign level_o  = level_q;
  assign period_o = period_q;

endmodule
